// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, ALU codes, state and instruction-class types
package ctrl_pkg;

   localparam logic [6:0] OPC_RTYPE  = 7'h33;
   localparam logic [6:0] OPC_IALU   = 7'h13;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JAL    = 7'h6F;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b110;

   // funct3 value that turns an R-type into an OR
   localparam logic [2:0] F3_OR = 3'b110;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BOOT,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      CLS_RTYPE,
      CLS_IALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JAL,
      CLS_ILLEGAL
   } insn_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode decoder producing class and datapath selects
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [31:0]  ir,
   output insn_class_t  cls,
   output logic         alu_src,
   output logic [2:0]   op,
   output logic         mem2reg,
   output logic         isbranch,
   output logic         isjump
);

   // register fields and immediates belong to the datapath, not to control
   logic unused_ir_bits;
   assign unused_ir_bits = ^{ir[31:15], ir[11:7]};

   // classify the opcode and derive the selects held for EXEC..WB
   always_comb begin
      cls      = CLS_ILLEGAL;
      alu_src  = 1'b1;
      op       = ALU_ADD;
      mem2reg  = 1'b0;
      isbranch = 1'b0;
      isjump   = 1'b0;
      case (ir[6:0])
         OPC_RTYPE: begin
            cls     = CLS_RTYPE;
            alu_src = 1'b0;
            op      = (ir[14:12] == F3_OR) ? ALU_OR : ALU_ADD;
         end
         OPC_IALU:  cls = CLS_IALU;
         OPC_LOAD: begin
            cls     = CLS_LOAD;
            mem2reg = 1'b1;
         end
         OPC_STORE: cls = CLS_STORE;
         OPC_BRANCH: begin
            cls      = CLS_BRANCH;
            alu_src  = 1'b0;
            op       = ALU_SUB;
            isbranch = 1'b1;
         end
         OPC_JAL: begin
            cls    = CLS_JAL;
            isjump = 1'b1;
         end
         default:   cls = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control sequencer; ILLEGAL_TRAP_EN makes illegal opcodes halt
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int MAX_INSNS = 43,
   parameter int CNT_W     = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       ins,
   output logic              int_o,
   output logic              pc_we,
   output logic              reg_write,
   output logic              alu_src,
   output logic [2:0]        op,
   output logic              mem_read,
   output logic              mem_write,
   output logic              mem2reg,
   output logic              isbranch,
   output logic              isjump,
   output logic              busy,
   output logic              halted,
   output logic [CNT_W-1:0]  retired,
   output logic              illegal
);

   state_t       state, next_state, retire_target;
   logic [31:0]  ir;
   insn_class_t  dec_cls;
   logic         dec_alu_src, dec_mem2reg, dec_isbranch, dec_isjump;
   logic [2:0]   dec_op;
   logic         retire_pulse;
   logic [CNT_W-1:0] retired_inc;

   ctrl_decode u_decode (
      .ir       (ir),
      .cls      (dec_cls),
      .alu_src  (dec_alu_src),
      .op       (dec_op),
      .mem2reg  (dec_mem2reg),
      .isbranch (dec_isbranch),
      .isjump   (dec_isjump)
   );

   // the boot PC load is not an instruction, so it never counts as a retire
   assign retire_pulse  = pc_we && (state != S_BOOT);
   assign retired_inc   = (&retired) ? retired : retired + 1'b1;
   assign retire_target = (retired_inc == CNT_W'(MAX_INSNS)) ? S_HALT : S_FETCH;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // instruction register, loaded once per instruction in FETCH
   always_ff @(posedge clk) begin
      if (reset)                 ir <= '0;
      else if (state == S_FETCH) ir <= ins;
   end

   // saturating retire counter, cleared when a halted run is restarted
   always_ff @(posedge clk) begin
      if (reset)                          retired <= '0;
      else if (state == S_HALT && start)  retired <= '0;
      else if (retire_pulse)              retired <= retired_inc;
   end

`ifdef ILLEGAL_TRAP_EN
   // sticky illegal-opcode flag; only reset clears it
   always_ff @(posedge clk) begin
      if (reset)                                         illegal <= 1'b0;
      else if (state == S_EXEC && dec_cls == CLS_ILLEGAL) illegal <= 1'b1;
   end
`else
   assign illegal = 1'b0;
`endif

   // next-state sequencing through the instruction phases
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (start) next_state = S_BOOT;
         S_BOOT:   next_state = S_FETCH;
         S_FETCH:  next_state = S_DECODE;
         S_DECODE: next_state = S_EXEC;
         S_EXEC: begin
            case (dec_cls)
               CLS_BRANCH:          next_state = retire_target;
               CLS_LOAD, CLS_STORE: next_state = S_MEM;
`ifdef ILLEGAL_TRAP_EN
               CLS_ILLEGAL:         next_state = S_HALT;
`else
               CLS_ILLEGAL:         next_state = retire_target;
`endif
               default:             next_state = S_WB;
            endcase
         end
         S_MEM:    next_state = (dec_cls == CLS_LOAD) ? S_WB : retire_target;
         S_WB:     next_state = retire_target;
         S_HALT:   if (start) next_state = S_BOOT;
         default:  next_state = S_IDLE;
      endcase
   end

   // Moore outputs: phase strobes gated by state, decoded selects held EXEC..WB
   always_comb begin
      int_o     = 1'b0;
      pc_we     = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      alu_src   = 1'b1;
      op        = ALU_ADD;
      mem2reg   = 1'b0;
      isbranch  = 1'b0;
      isjump    = 1'b0;
      busy      = (state != S_IDLE) && (state != S_HALT);
      halted    = (state == S_HALT);
      if (state == S_EXEC || state == S_MEM || state == S_WB) begin
         alu_src  = dec_alu_src;
         op       = dec_op;
         mem2reg  = dec_mem2reg;
         isbranch = dec_isbranch;
         isjump   = dec_isjump;
      end
      case (state)
         S_BOOT: begin
            int_o = 1'b1;
            pc_we = 1'b1;
         end
         S_EXEC: begin
`ifdef ILLEGAL_TRAP_EN
            pc_we = (dec_cls == CLS_BRANCH);
`else
            pc_we = (dec_cls == CLS_BRANCH) || (dec_cls == CLS_ILLEGAL);
`endif
         end
         S_MEM: begin
            mem_read  = (dec_cls == CLS_LOAD);
            mem_write = (dec_cls == CLS_STORE);
            pc_we     = (dec_cls == CLS_STORE);
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_we     = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl (honours ILLEGAL_TRAP_EN)
module tb_multicycle_ctrl;

   localparam int TB_MAX = 3;
   localparam int CW     = 16;

   localparam logic [31:0] I_ADD = 32'h00C58533;
   localparam logic [31:0] I_OR  = 32'h00C5E533;
   localparam logic [31:0] I_LD  = 32'h0005A503;
   localparam logic [31:0] I_ST  = 32'h00A5A023;
   localparam logic [31:0] I_BR  = 32'h00B50463;
   localparam logic [31:0] I_JAL = 32'h008000EF;
   localparam logic [31:0] I_ADI = 32'h00150513;
   localparam logic [31:0] I_ILL = 32'h0000007F;

   logic clk = 1'b0;
   logic reset, start;
   logic [31:0] ins;
   logic int_o, pc_we, reg_write, alu_src, mem_read, mem_write, mem2reg;
   logic isbranch, isjump, busy, halted, illegal;
   logic [2:0] op;
   logic [CW-1:0] retired;

   multicycle_ctrl #(.MAX_INSNS(TB_MAX), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .ins(ins),
      .int_o(int_o), .pc_we(pc_we), .reg_write(reg_write), .alu_src(alu_src),
      .op(op), .mem_read(mem_read), .mem_write(mem_write), .mem2reg(mem2reg),
      .isbranch(isbranch), .isjump(isjump), .busy(busy), .halted(halted),
      .retired(retired), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef enum {K_ADD, K_OR, K_IALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_ILL} kind_t;

   typedef struct packed {
      logic int_o, pc_we, reg_write, alu_src;
      logic [2:0] op;
      logic mem_read, mem_write, mem2reg, isbranch, isjump, busy, halted, illegal;
      logic [CW-1:0] retired;
   } vec_t;

   typedef struct {
      vec_t        v;
      string       tag;
      logic [31:0] i;   // ins driven after this cycle is checked
      logic        s;   // start driven after this cycle is checked
   } entry_t;

   entry_t sb[$];
   int     n_run  = 0;
   int     n_fail = 0;
   int     exp_ret;
   logic   exp_ill;

   function automatic vec_t obs();
      return vec_t'({int_o, pc_we, reg_write, alu_src, op, mem_read, mem_write,
                     mem2reg, isbranch, isjump, busy, halted, illegal, retired});
   endfunction

   function automatic vec_t base_vec(input logic b, input logic h);
      vec_t v;
      v = '0;
      v.alu_src = 1'b1;
      v.op      = 3'b010;
      v.busy    = b;
      v.halted  = h;
      v.illegal = exp_ill;
      v.retired = CW'(exp_ret);
      return v;
   endfunction

   task automatic push(input vec_t v, input string tag, input logic [31:0] i, input logic s);
      entry_t e;
      e.v = v; e.tag = tag; e.i = i; e.s = s;
      sb.push_back(e);
   endtask

   task automatic push_boot(input logic [31:0] i);
      vec_t v;
      v = base_vec(1'b1, 1'b0);
      v.int_o = 1'b1;
      v.pc_we = 1'b1;
      push(v, "boot", i, 1'b0);
   endtask

   // expected per-phase outputs for one instruction, from the phase table
   task automatic push_insn(input kind_t k, input logic [31:0] i);
      vec_t d, v;
      d = base_vec(1'b1, 1'b0);
      case (k)
         K_ADD:    d.alu_src = 1'b0;
         K_OR:     begin d.alu_src = 1'b0; d.op = 3'b001; end
         K_LOAD:   d.mem2reg = 1'b1;
         K_BRANCH: begin d.alu_src = 1'b0; d.op = 3'b110; d.isbranch = 1'b1; end
         K_JAL:    d.isjump = 1'b1;
         default:  ;
      endcase
      push(base_vec(1'b1, 1'b0), "fetch", i, 1'b0);
      push(base_vec(1'b1, 1'b0), "decode", i, 1'b1);  // start while busy must be ignored
      v = d;
      if (k == K_BRANCH) v.pc_we = 1'b1;
`ifndef ILLEGAL_TRAP_EN
      if (k == K_ILL) v.pc_we = 1'b1;
`endif
      push(v, "exec", i, 1'b0);
      if (k == K_LOAD || k == K_STORE) begin
         v = d;
         if (k == K_LOAD) v.mem_read = 1'b1;
         else begin v.mem_write = 1'b1; v.pc_we = 1'b1; end
         push(v, "mem", i, 1'b0);
      end
      if (k != K_BRANCH && k != K_STORE && k != K_ILL) begin
         v = d;
         v.reg_write = 1'b1;
         v.pc_we     = 1'b1;
         push(v, "wb", i, 1'b0);
      end
`ifdef ILLEGAL_TRAP_EN
      if (k == K_ILL) exp_ill = 1'b1;
      else            exp_ret++;
`else
      exp_ret++;
`endif
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      sb.delete();
      exp_ret = 0;
      exp_ill = 1'b0;
   endtask

   task automatic test_reset();
      vec_t want;
      reset = 1'b1;
      start = 1'b0;
      exp_ret = 0;
      exp_ill = 1'b0;
      want = base_vec(1'b0, 1'b0);
      repeat (2) @(negedge clk);
      n_run++;
      if (obs() !== want) begin
         n_fail++;
         $display("FAIL reset_state: got %h want %h", obs(), want);
      end
      reset = 1'b0;
      @(negedge clk);
      n_run++;
      if (obs() !== want) begin
         n_fail++;
         $display("FAIL idle_hold: got %h want %h", obs(), want);
      end
   endtask

   task automatic test_single(input kind_t k, input logic [31:0] i, input string name);
      entry_t e;
      apply_reset();
      push_boot(i);
      push_insn(k, i);
      push(base_vec(1'b1, 1'b0), "fetch_next", i, 1'b0);
      ins   = i;
      start = 1'b1;
      while (sb.size() != 0) begin
         @(negedge clk);
         e = sb.pop_front();
         n_run++;
         if (obs() !== e.v) begin
            n_fail++;
            $display("FAIL %s[%s]: got %h want %h", name, e.tag, obs(), e.v);
         end
         ins   = e.i;
         start = e.s;
      end
   endtask

   task automatic test_halt();
      entry_t e;
      apply_reset();
      push_boot(I_ADI);
      repeat (TB_MAX) push_insn(K_IALU, I_ADI);
      push(base_vec(1'b0, 1'b1), "halt", I_ADI, 1'b0);
      push(base_vec(1'b0, 1'b1), "halt_quiet", I_ADI, 1'b1);
      exp_ret = 0;
      push_boot(I_ADI);
      push(base_vec(1'b1, 1'b0), "fetch_after_restart", I_ADI, 1'b0);
      ins   = I_ADI;
      start = 1'b1;
      while (sb.size() != 0) begin
         @(negedge clk);
         e = sb.pop_front();
         n_run++;
         if (obs() !== e.v) begin
            n_fail++;
            $display("FAIL halt[%s]: got %h want %h", e.tag, obs(), e.v);
         end
         ins   = e.i;
         start = e.s;
      end
   endtask

   task automatic test_back_to_back();
      entry_t e;
      apply_reset();
      push_boot(I_ADD);
      push_insn(K_ADD, I_ADD);
      push_insn(K_LOAD, I_LD);
      push_insn(K_STORE, I_ST);
      push(base_vec(1'b0, 1'b1), "halt", I_ST, 1'b0);
      ins   = I_ADD;
      start = 1'b1;
      while (sb.size() != 0) begin
         @(negedge clk);
         e = sb.pop_front();
         n_run++;
         if (obs() !== e.v) begin
            n_fail++;
            $display("FAIL back_to_back[%s]: got %h want %h", e.tag, obs(), e.v);
         end
         ins   = e.i;
         start = e.s;
      end
   endtask

   task automatic test_illegal();
      entry_t e;
      apply_reset();
      push_boot(I_ILL);
      push_insn(K_ILL, I_ILL);
`ifdef ILLEGAL_TRAP_EN
      push(base_vec(1'b0, 1'b1), "halt", I_ILL, 1'b1);
      push_boot(I_ILL);  // illegal stays set across restart
`else
      push(base_vec(1'b1, 1'b0), "fetch_next", I_ILL, 1'b0);
`endif
      ins   = I_ILL;
      start = 1'b1;
      while (sb.size() != 0) begin
         @(negedge clk);
         e = sb.pop_front();
         n_run++;
         if (obs() !== e.v) begin
            n_fail++;
            $display("FAIL illegal[%s]: got %h want %h", e.tag, obs(), e.v);
         end
         ins   = e.i;
         start = e.s;
      end
   endtask

   task automatic test_reset_mid_mem();
      entry_t e;
      vec_t   want;
      apply_reset();
      push_boot(I_LD);
      push_insn(K_LOAD, I_LD);
      ins   = I_LD;
      start = 1'b1;
      repeat (5) begin  // boot, fetch, decode, exec, mem
         @(negedge clk);
         e = sb.pop_front();
         n_run++;
         if (obs() !== e.v) begin
            n_fail++;
            $display("FAIL reset_mid_mem[%s]: got %h want %h", e.tag, obs(), e.v);
         end
         ins   = e.i;
         start = e.s;
      end
      sb.delete();
      reset   = 1'b1;
      exp_ret = 0;
      exp_ill = 1'b0;
      want    = base_vec(1'b0, 1'b0);
      @(negedge clk);
      n_run++;
      if (obs() !== want) begin
         n_fail++;
         $display("FAIL reset_mid_mem[after_reset]: got %h want %h", obs(), want);
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      ins   = '0;
      test_reset();
      test_single(K_ADD,    I_ADD, "add");
      test_single(K_OR,     I_OR,  "or");
      test_single(K_LOAD,   I_LD,  "load");
      test_single(K_STORE,  I_ST,  "store");
      test_single(K_BRANCH, I_BR,  "branch");
      test_single(K_JAL,    I_JAL, "jal");
      test_halt();
      test_back_to_back();
      test_illegal();
      test_reset_mid_mem();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer that sits directly upstream of the single-cycle datapath (fetch, decode, execute, data memory, writeback and PC-select stages).
- Replaces the hand-driven control stimulus currently written inline in the bench.
- Registers the fetched instruction, decodes its opcode, and steps through FETCH/DECODE/EXEC/MEM/WB phases.
- Asserts datapath write strobes and the PC write enable only in the correct phase; issues the boot interrupt that loads the entry point.

Parameters:
- MAX_INSNS, 43: number of retired instructions after which the block halts.
- CNT_W, 16: width of the retire counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or HALT.
- ins  in  32  instruction from the fetch stage.
- int_o  out  1  boot interrupt to the PC stage (PC takes the entry point).
- pc_we  out  1  PC register write enable.
- reg_write  out  1  register file write strobe.
- alu_src  out  1  ALU B select: 1 = immediate.
- op  out  3  ALU operation.
- mem_read  out  1  data memory read strobe.
- mem_write  out  1  data memory write strobe.
- mem2reg  out  1  writeback select: 1 = memory.
- isbranch  out  1  branch select to the PC stage.
- isjump  out  1  jump select to the PC stage.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- retired  out  CNT_W  count of retired instructions.
- illegal  out  1  sticky illegal-opcode flag.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (including mid-run):
  - state = IDLE, retired = 0, illegal = 0, ir = 0.
  - All strobes (pc_we, reg_write, mem_read, mem_write, int_o, isbranch, isjump) = 0; mem2reg = 0.
  - Defaults alu_src = 1, op = 3'b010.
- States: IDLE, BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs are Moore: a function of state and ir only.
- IDLE: start=1 → BOOT. Otherwise remain in IDLE.
- BOOT: int_o=1 and pc_we=1 for exactly one cycle, then → FETCH. BOOT does not count as a retire.
- FETCH: ir <= ins, then → DECODE.
- DECODE: classify ir[6:0], then → EXEC. Classes:
  - 0x33 R-type
  - 0x13 I-ALU
  - 0x03 load
  - 0x23 store
  - 0x63 branch
  - 0x6F jal
  - anything else: illegal
- Decoded controls are held constant from EXEC through WB. Defaults: alu_src=1, op=010.
  - R-type: alu_src=0. op=001 if ir[14:12]=3'b110, else 010.
  - Branch: alu_src=0, op=110, isbranch=1.
  - Jal: isjump=1.
  - Load: mem2reg=1.
- EXEC transitions:
  - Branch: pc_we=1, → FETCH (retire).
  - Load or store: → MEM.
  - R-type, I-ALU, jal: → WB.
- MEM:
  - Load: mem_read=1, → WB.
  - Store: mem_write=1, pc_we=1, → FETCH (retire).
- WB: reg_write=1, pc_we=1, → FETCH (retire).
- Latency, FETCH to retire:
  - Branch: 3 cycles.
  - R-type, I-ALU, store, jal: 4 cycles.
  - Load: 5 cycles.
- Retire: every pc_we outside BOOT increments retired. When the incremented value equals MAX_INSNS, the next state is HALT instead of FETCH. The counter saturates and does not wrap.
- HALT: all strobes 0. start=1 → BOOT with retired cleared to 0; illegal is preserved.
- start while busy: ignored.
- Strobes: at most one of reg_write, mem_write, or int_o is high in any cycle. Strobes are never high in FETCH or DECODE.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an illegal opcode goes EXEC → HALT with no pc_we and no retire, and sets illegal=1.
- Undefined: an illegal opcode is treated as a NOP. EXEC asserts pc_we=1, counts a retire, → FETCH. illegal is tied to 0.

Decomposition:
- Shared package ctrl_pkg:
  - Opcode constants OPC_RTYPE, OPC_IALU, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL.
  - ALU codes ALU_ADD=010, ALU_OR=001, ALU_SUB=110.
  - State enum.
  - Instruction-class enum.
- Sub-module ctrl_decode: combinational; maps ir → class, alu_src, op, mem2reg, isbranch, isjump. The FSM in multicycle_ctrl gates the phase strobes.

Test Plan:
- Reset then start, ins=0x00C58533 (add): BOOT int_o=1 for 1 cycle. Then 4 cycles later WB shows reg_write=1, pc_we=1, alu_src=0, op=010; retired=1.
- R-type with funct3=110 (0x00C5E533): op=001 throughout EXEC/WB.
- Load 0x0005A503: mem_read=1 in MEM, mem2reg=1 in WB, reg_write=1 only in the 5th cycle; store 0x00A5A023: mem_write=1 and pc_we=1 in MEM, reg_write never 1.
- Branch 0x00B50463: isbranch=1, op=110, alu_src=0; pc_we=1 in EXEC (3rd cycle); reg_write stays 0.
- MAX_INSNS=3 with an addi stream: halted=1 after the 3rd retire, retired=3, no further strobes; start → BOOT, retired=0.
- ins=0x0000007F: with ILLEGAL_TRAP_EN, halted=1 and illegal=1 with no pc_we; without it, pc_we=1 in EXEC and retired increments. Reset asserted during MEM clears all outputs the next cycle.
